// File: rtl/bit_scan_ctrl.sv
// bit_scan_ctrl: serial per-bit AND checker for two operand words.
// One bit index is examined per clock, from 0 up to len-1, where
// len = min(scan_len, WIDTH). Reports pass/fail, the number of failing
// bits and the lowest failing index.
//
// Handshake: start is a single-cycle request sampled only while the
// controller is idle (busy low); it is ignored while busy is high. abort
// beats start in the same idle cycle and otherwise only acts during a scan.
// done is a one-cycle pulse, and the result outputs (pass, aborted,
// fail_cnt, fail_valid, first_fail_idx) are valid in that cycle. They hold
// until the next accepted start.
module bit_scan_ctrl #(
   parameter int WIDTH = 32,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [IDX_W:0]   scan_len,
   input  logic [WIDTH-1:0] foo,
   input  logic [WIDTH-1:0] bar,
   output logic             busy,
   output logic [IDX_W-1:0] bit_idx,
   output logic             done,
   output logic             pass,
   output logic             aborted,
   output logic [IDX_W:0]   fail_cnt,
   output logic             fail_valid,
   output logic [IDX_W-1:0] first_fail_idx,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(WIDTH);
   localparam logic [IDX_W:0] LEN_ONE = (IDX_W+1)'(1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_foo;
   logic [WIDTH-1:0] r_bar;
   logic [IDX_W:0]   r_len;
   logic [IDX_W-1:0] r_idx;
   logic             r_pass;
   logic             r_aborted;
   logic [IDX_W:0]   r_fail_cnt;
   logic             r_fail_valid;
   logic [IDX_W-1:0] r_first_fail;

   logic [IDX_W:0]   w_len;
   logic             w_hit;
   logic             w_last;
   logic [IDX_W:0]   w_cnt_next;

   // Clamp the requested length, evaluate the current bit and the next count.
   always_comb begin
      w_len      = (scan_len > LEN_MAX) ? LEN_MAX : scan_len;
      w_hit      = r_foo[r_idx] & r_bar[r_idx];
      w_last     = ({1'b0, r_idx} == (r_len - LEN_ONE));
      w_cnt_next = w_hit ? r_fail_cnt : (r_fail_cnt + LEN_ONE);
   end

   // Controller FSM plus shadow operands and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_foo        <= '0;
         r_bar        <= '0;
         r_len        <= '0;
         r_idx        <= '0;
         r_pass       <= 1'b0;
         r_aborted    <= 1'b0;
         r_fail_cnt   <= '0;
         r_fail_valid <= 1'b0;
         r_first_fail <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && !abort) begin
                  r_foo        <= foo;
                  r_bar        <= bar;
                  r_len        <= w_len;
                  r_idx        <= '0;
                  r_aborted    <= 1'b0;
                  r_fail_cnt   <= '0;
                  r_fail_valid <= 1'b0;
                  r_first_fail <= '0;
                  if (w_len == '0) begin
                     // Nothing to check: trivially passing.
                     r_state <= ST_DONE;
                     r_pass  <= 1'b1;
                  end else begin
                     r_state <= ST_SCAN;
                     r_pass  <= 1'b0;
                  end
               end
            end
            ST_SCAN: begin
               if (abort) begin
                  // Current bit is skipped; partial counts are kept.
                  r_state   <= ST_DONE;
                  r_aborted <= 1'b1;
                  r_pass    <= 1'b0;
               end else begin
                  r_fail_cnt <= w_cnt_next;
                  if (!w_hit && !r_fail_valid) begin
                     r_fail_valid <= 1'b1;
                     r_first_fail <= r_idx;
                  end
                  if (w_last) begin
                     r_state <= ST_DONE;
                     r_pass  <= (w_cnt_next == '0);
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs are decoded directly from state and result registers.
   always_comb begin
      busy           = (r_state == ST_SCAN) || (r_state == ST_DONE);
      done           = (r_state == ST_DONE);
      bit_idx        = r_idx;
      pass           = r_pass;
      aborted        = r_aborted;
      fail_cnt       = r_fail_cnt;
      fail_valid     = r_fail_valid;
      first_fail_idx = r_first_fail;
      dbg_state      = r_state;
   end

endmodule

// File: tb/tb_bit_scan_ctrl.sv
// Directed bench for bit_scan_ctrl with hand-computed expectations.
module tb_bit_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [5:0]  scan_len;
  logic [31:0] foo;
  logic [31:0] bar;
  logic        busy;
  logic [4:0]  bit_idx;
  logic        done;
  logic        pass;
  logic        aborted;
  logic [5:0]  fail_cnt;
  logic        fail_valid;
  logic [4:0]  first_fail_idx;
  logic [1:0]  dbg_state;

  int total;
  int bad;
  int dcyc;

  bit_scan_ctrl #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .scan_len       (scan_len),
    .foo            (foo),
    .bar            (bar),
    .busy           (busy),
    .bit_idx        (bit_idx),
    .done           (done),
    .pass           (pass),
    .aborted        (aborted),
    .fail_cnt       (fail_cnt),
    .fail_valid     (fail_valid),
    .first_fail_idx (first_fail_idx),
    .dbg_state      (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives a start in cycle 0 (the cycle after the next edge), then returns
  // in the cycle where done is seen, giving that cycle number in dcyc_o
  // (-1 on timeout). Operand inputs are inverted during the scan to show
  // the shadow copies are used. Extra start pulses at cycles s1/s2 and an
  // abort at cycle ab (0 = none) are optional.
  task automatic run(input logic [31:0] f, input logic [31:0] b, input logic [5:0] l,
                     input int ab, input int s1, input int s2, output int dcyc_o);
    @(posedge clk); #1;
    foo = f; bar = b; scan_len = l; start = 1'b1; abort = 1'b0;
    dcyc_o = -1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      start    = (k == s1) || (k == s2);
      abort    = (k == ab);
      foo      = ~f;
      bar      = ~b;
      scan_len = 6'd1;
      if (done) begin
        dcyc_o = k;
        break;
      end
    end
    abort = 1'b0;
  endtask

  // Checks done is a single pulse and the controller is back in idle.
  task automatic after_done(input string tag);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    scan_len = '0; foo = '0; bar = '0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_fcnt", fail_cnt, 6'd0);
    chk("rst_fidx", first_fail_idx, 5'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: two failing bits (0 and 2) in the first ten
    run(32'hFFFF_FFFA, 32'hFFFF_FFFB, 6'd10, 0, 0, 0, dcyc);
    chk("t1_lat", dcyc, 11);
    chk("t1_pass", pass, 1'b0);
    chk("t1_fcnt", fail_cnt, 6'd2);
    chk("t1_fidx", first_fail_idx, 5'd0);
    chk("t1_fvld", fail_valid, 1'b1);
    chk("t1_busy", busy, 1'b1);
    after_done("t1");

    // 2: full-width all-ones scan
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd32, 0, 0, 0, dcyc);
    chk("t2_lat", dcyc, 33);
    chk("t2_pass", pass, 1'b1);
    chk("t2_fcnt", fail_cnt, 6'd0);
    chk("t2_fvld", fail_valid, 1'b0);
    after_done("t2");

    // 3a: zero length
    run(32'h0, 32'h0, 6'd0, 0, 0, 0, dcyc);
    chk("t3a_lat", dcyc, 1);
    chk("t3a_pass", pass, 1'b1);
    chk("t3a_fcnt", fail_cnt, 6'd0);
    after_done("t3a");

    // 3b: length 40 clamps to 32
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd40, 0, 0, 0, dcyc);
    chk("t3b_lat", dcyc, 33);
    chk("t3b_pass", pass, 1'b1);
    after_done("t3b");

    // first failure in the middle: bits 4..7 of foo clear
    run(32'hFFFF_FF0F, 32'hFFFF_FFFF, 6'd8, 0, 0, 0, dcyc);
    chk("mid_lat", dcyc, 9);
    chk("mid_fcnt", fail_cnt, 6'd4);
    chk("mid_fidx", first_fail_idx, 5'd4);
    chk("mid_pass", pass, 1'b0);
    after_done("mid");

    // 4: abort in cycle 4, bits 0..2 evaluated
    run(32'h0, 32'hFFFF_FFFF, 6'd10, 4, 0, 0, dcyc);
    chk("t4_lat", dcyc, 5);
    chk("t4_abrt", aborted, 1'b1);
    chk("t4_pass", pass, 1'b0);
    chk("t4_fcnt", fail_cnt, 6'd3);
    chk("t4_fidx", first_fail_idx, 5'd0);
    after_done("t4");

    // start together with abort in idle: no scan; results held
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 1'b0);
    chk("sa_hold", fail_cnt, 6'd3);
    @(posedge clk); #1;
    chk("sa_busy2", busy, 1'b0);

    // 5: start during scan (3) and during done (11) ignored; start at 12 accepted
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd10, 0, 3, 11, dcyc);
    chk("t5_lat", dcyc, 11);
    chk("t5_pass", pass, 1'b1);
    run(32'hFFFF_FFFE, 32'hFFFF_FFFF, 6'd10, 0, 0, 0, dcyc);
    chk("t5_lat2", dcyc + 12, 23);
    chk("t5_fcnt2", fail_cnt, 6'd1);
    after_done("t5");

    // 6: reset in cycle 5 of a scan, new start in cycle 8
    @(posedge clk); #1;
    foo = 32'h0; bar = 32'h0; scan_len = 6'd10; start = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("t6_pre_fcnt", fail_cnt, 6'd4);
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_done", done, 1'b0);
    chk("t6_fcnt", fail_cnt, 6'd0);
    chk("t6_fvld", fail_valid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(32'hFFFF_FFFF, 32'hFFFF_FFF7, 6'd4, 0, 0, 0, dcyc);
    chk("t6_lat", dcyc + 8, 13);
    chk("t6_fidx", first_fail_idx, 5'd3);
    chk("t6_fcnt2", fail_cnt, 6'd1);
    after_done("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
